udp_tx_packetizer8: RTL and testbench
=====================================

# udp_tx_packetizer8

Builds fixed-length UDP payloads from a user byte stream and writes them into one UDP TX port of the 8-bit UDP core: the user-side data FIFO and status FIFO of a single TX channel. The byte stream is cut into packets of exactly `PAYLOAD_LEN` bytes, and each packet is followed by one 96-bit status word carrying its destination. A flush request, and optionally an idle timeout, closes a partial packet by zero-padding it to full length. One instance is placed per TX channel in the user clock domain.

## Interface
Parameters:
- `PAYLOAD_LEN`, 1024: bytes per packet. Legal range 1..4096.
- `DATA_FIFO_DEPTH`, 8192: capacity in words of the downstream data FIFO. Matches the 13-bit `wrusedw`.
- `TIMEOUT_CYCLES`, 65535: idle cycles before an automatic flush. Used only with `PKT_TIMEOUT_EN`.

Ports:
- `user_clk`  in  1  clock; also the downstream FIFOs' write clock.
- `user_sync_rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  user byte valid.
- `in_data`  in  8  user byte.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `in_flush`  in  1  single-cycle request to close the current packet.
- `dest_port`  in  16  destination UDP port; sampled at packet start.
- `dest_mac`  in  48  destination MAC; sampled at packet start.
- `dest_ip`  in  32  destination IP; sampled at packet start.
- `wrreq_data_udp_txfifo`  out  1  data FIFO write.
- `data_to_udp_txfifo`  out  8  data FIFO word.
- `wrusedw_data_udp_txfifo`  in  13  data FIFO fill level.
- `wrreq_status_udp_txfifo`  out  1  status FIFO write.
- `status_to_udp_txfifo`  out  96  status word = {port[95:80], mac[79:32], ip[31:0]}.
- `wrfull_status_udp_txfifo`  in  1  status FIFO full.
- `pkt_count`  out  32  packets committed; wraps at 2^32.
- `busy`  out  1  high in any state other than IDLE.

## Operation
The block is a five-state machine: IDLE, WAIT_ROOM, FILL, PAD, COMMIT.

- **IDLE**
  - On `in_valid` or `in_flush`, latch `dest_*` into `dst_q` and go to WAIT_ROOM.
  - A flush arriving in IDLE with no data pending is ignored: no empty packet is created.
- **WAIT_ROOM**
  - Go to FILL when `wrusedw_data_udp_txfifo <= DATA_FIFO_DEPTH - PAYLOAD_LEN - 2` and `!wrfull_status_udp_txfifo`.
  - The 2-word margin absorbs the `wrusedw` update latency.
  - The room check is what guarantees the data FIFO never overflows; `wrfull_data` is therefore not used.
- **FILL**
  - `in_ready` = 1. Each handshake writes one byte and increments `byte_cnt` (13-bit).
  - When the byte that makes `byte_cnt == PAYLOAD_LEN` is accepted, go to COMMIT.
  - `in_flush` with `byte_cnt > 0` goes to PAD.
  - `in_flush` with `byte_cnt == 0` returns to IDLE without writing anything.
  - If `in_flush` and a handshake occur in the same cycle, the byte is accepted first, then the flush is evaluated.
- **PAD**
  - `in_ready` = 0. Write `8'h00` every cycle until `byte_cnt == PAYLOAD_LEN`, then go to COMMIT.
- **COMMIT**
  - Write `dst_q` to the status FIFO, increment `pkt_count`, clear `byte_cnt`, go to IDLE.
  - Space in the status FIFO was already checked in WAIT_ROOM; the single writer keeps that valid.
- Destination changes during a packet have no effect until the next IDLE→WAIT_ROOM transition.
- Reset mid-packet abandons it: bytes already written stay in the FIFO unpaired with a status word. The system-level rule is that reset of this block is accompanied by FIFO clear.

## Timing
- `in_ready` is combinational from state (FILL only).
- `wrreq_data_udp_txfifo` / `data_to_udp_txfifo` are registered, one cycle after the handshake or pad cycle.
- `wrreq_status_udp_txfifo` pulses for one cycle, one cycle after the COMMIT state. The status write therefore follows the last data write by exactly one cycle.
- Minimum packet period is `PAYLOAD_LEN + 3` cycles (IDLE, WAIT_ROOM, PAYLOAD_LEN fills, COMMIT) under continuous input with room available.
- Reset values: `in_ready` 0, `wrreq_data_udp_txfifo` 0, `data_to_udp_txfifo` 0, `wrreq_status_udp_txfifo` 0, `status_to_udp_txfifo` 0, `pkt_count` 0, `busy` 0, state IDLE.

## Configuration
- `PKT_TIMEOUT_EN` defined:
  - In FILL, a 16-bit idle counter clears on every handshake and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES` with `byte_cnt > 0`, the block behaves as if `in_flush` were asserted (go to PAD).
  - The counter is held at 0 outside FILL.
- `PKT_TIMEOUT_EN` undefined: no idle counter; only `in_flush` closes a partial packet.

## Test plan
- **Full packet:** `PAYLOAD_LEN=4`, stream 0x01..0x08 continuously → data writes 01,02,03,04 then status, then 05..08 then status; `pkt_count=2`; status words equal the `dest_*` values sampled at each packet start.
- **Flush pad:** `PAYLOAD_LEN=8`, 3 bytes AA,BB,CC then `in_flush` → data AA,BB,CC,00,00,00,00,00, one status write; `in_flush` in IDLE → no writes.
- **Backpressure:** `wrusedw_data_udp_txfifo = 8190` with `PAYLOAD_LEN=4` → `in_ready` stays 0 in WAIT_ROOM; lower to 8186 → FILL entered next cycle.
- **Status full:** `wrfull_status_udp_txfifo=1` → no data written until it deasserts.
- **Timeout (`PKT_TIMEOUT_EN`, `TIMEOUT_CYCLES=10`):** 2 bytes then idle → padding starts 10 cycles after the last handshake. Without the macro → no writes after the 2 bytes.
- **Reset mid-FILL:** assert `user_sync_rst` after 2 of 4 bytes → all outputs 0 the next cycle, `pkt_count=0`, and a new packet starts cleanly afterwards.

Source files
------------

// File: rtl/udp_tx_packetizer8.sv
// Cuts a byte stream into fixed-length UDP payloads for one TX channel of the 8-bit UDP core.
// Optional idle-timeout auto-flush is enabled by defining PKT_TIMEOUT_EN.
module udp_tx_packetizer8 #(
    parameter int PAYLOAD_LEN     = 1024,
    parameter int DATA_FIFO_DEPTH = 8192,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic        user_clk,
    input  logic        user_sync_rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        in_flush,
    input  logic [15:0] dest_port,
    input  logic [47:0] dest_mac,
    input  logic [31:0] dest_ip,
    output logic        wrreq_data_udp_txfifo,
    output logic [7:0]  data_to_udp_txfifo,
    input  logic [12:0] wrusedw_data_udp_txfifo,
    output logic        wrreq_status_udp_txfifo,
    output logic [95:0] status_to_udp_txfifo,
    input  logic        wrfull_status_udp_txfifo,
    output logic [31:0] pkt_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        FILL,
        PAD,
        COMMIT
    } state_t;

    localparam logic [12:0] LEN      = 13'(PAYLOAD_LEN);
    localparam logic [13:0] ROOM_MAX = 14'(DATA_FIFO_DEPTH - PAYLOAD_LEN - 2);

    state_t      state_q;
    state_t      state_d;
    logic [12:0] byte_cnt_q;
    logic [12:0] byte_cnt_d;
    logic [12:0] cnt_inc;
    logic [95:0] dst_q;
    logic        wr_data_q;
    logic [7:0]  data_q;
    logic        wr_stat_q;
    logic [95:0] stat_q;
    logic [31:0] pkt_q;
    logic        hs;
    logic        room_ok;
    logic        latch_dst;
    logic        timeout;

    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != IDLE);
    assign hs       = in_valid & in_ready;
    assign cnt_inc  = byte_cnt_q + 13'd1;
    assign room_ok  = ({1'b0, wrusedw_data_udp_txfifo} <= ROOM_MAX) &&
                      !wrfull_status_udp_txfifo;

`ifdef PKT_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_q;

    // Fires on the cycle that completes TIMEOUT_CYCLES idle FILL cycles
    assign timeout = !hs && (idle_q == IDLE_LAST) && (byte_cnt_q != 13'd0);

    always_ff @(posedge user_clk) begin
        if (user_sync_rst) begin
            idle_q <= 16'd0;
        end else if (state_q != FILL || hs) begin
            idle_q <= 16'd0;
        end else begin
            idle_q <= idle_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        latch_dst  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid || in_flush) begin
                    latch_dst = 1'b1;
                    state_d   = WAIT_ROOM;
                end
            end
            WAIT_ROOM: begin
                if (room_ok) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (hs) begin
                    byte_cnt_d = cnt_inc;
                end
                // An accepted byte is counted before a same-cycle flush is judged
                if (hs && cnt_inc == LEN) begin
                    state_d = COMMIT;
                end else if (in_flush || timeout) begin
                    state_d = (byte_cnt_d != 13'd0) ? PAD : IDLE;
                end
            end
            PAD: begin
                byte_cnt_d = cnt_inc;
                if (cnt_inc == LEN) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                byte_cnt_d = 13'd0;
                state_d    = IDLE;
            end
            default: begin
                byte_cnt_d = 13'd0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_sync_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 13'd0;
            dst_q      <= 96'd0;
            wr_data_q  <= 1'b0;
            data_q     <= 8'd0;
            wr_stat_q  <= 1'b0;
            stat_q     <= 96'd0;
            pkt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (latch_dst) begin
                dst_q <= {dest_port, dest_mac, dest_ip};
            end
            wr_data_q <= hs || (state_q == PAD);
            if (hs) begin
                data_q <= in_data;
            end else if (state_q == PAD) begin
                data_q <= 8'h00;
            end
            wr_stat_q <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                stat_q <= dst_q;
                pkt_q  <= pkt_q + 32'd1;
            end
        end
    end

    assign wrreq_data_udp_txfifo   = wr_data_q;
    assign data_to_udp_txfifo      = data_q;
    assign wrreq_status_udp_txfifo = wr_stat_q;
    assign status_to_udp_txfifo    = stat_q;
    assign pkt_count               = pkt_q;

endmodule

// File: tb/tb_udp_tx_packetizer8.sv
// Directed bench for udp_tx_packetizer8: one instance with 4-byte and one with 8-byte payloads.
// Packet vectors are table driven; backpressure, reset and timeout are hand sequences.
module tb_udp_tx_packetizer8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        v4, v8, f4, f8;
    logic [15:0] dport;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [12:0] used;
    logic        sfull;

    logic        rdy4, wd4, ws4, busy4;
    logic [7:0]  d4;
    logic [95:0] s4;
    logic [31:0] pc4;
    logic        rdy8, wd8, ws8, busy8;
    logic [7:0]  d8;
    logic [95:0] s8;
    logic [31:0] pc8;

    always #5 clk = ~clk;

    udp_tx_packetizer8 #(
        .PAYLOAD_LEN(4), .DATA_FIFO_DEPTH(8192), .TIMEOUT_CYCLES(10)
    ) u4 (
        .user_clk(clk), .user_sync_rst(rst),
        .in_valid(v4), .in_data(in_data), .in_ready(rdy4), .in_flush(f4),
        .dest_port(dport), .dest_mac(dmac), .dest_ip(dip),
        .wrreq_data_udp_txfifo(wd4), .data_to_udp_txfifo(d4),
        .wrusedw_data_udp_txfifo(used),
        .wrreq_status_udp_txfifo(ws4), .status_to_udp_txfifo(s4),
        .wrfull_status_udp_txfifo(sfull),
        .pkt_count(pc4), .busy(busy4)
    );

    udp_tx_packetizer8 #(
        .PAYLOAD_LEN(8), .DATA_FIFO_DEPTH(8192), .TIMEOUT_CYCLES(10)
    ) u8 (
        .user_clk(clk), .user_sync_rst(rst),
        .in_valid(v8), .in_data(in_data), .in_ready(rdy8), .in_flush(f8),
        .dest_port(dport), .dest_mac(dmac), .dest_ip(dip),
        .wrreq_data_udp_txfifo(wd8), .data_to_udp_txfifo(d8),
        .wrusedw_data_udp_txfifo(used),
        .wrreq_status_udp_txfifo(ws8), .status_to_udp_txfifo(s8),
        .wrfull_status_udp_txfifo(sfull),
        .pkt_count(pc8), .busy(busy8)
    );

    // Write logs, sampled on the falling edge
    int          cyc = 0;
    logic [7:0]  dq4[$], dq8[$];
    int          dc4[$], dc8[$];
    logic [95:0] sq4[$], sq8[$];
    int          sc4[$], sc8[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wd4) begin dq4.push_back(d4); dc4.push_back(cyc); end
        if (wd8) begin dq8.push_back(d8); dc8.push_back(cyc); end
        if (ws4) begin sq4.push_back(s4); sc4.push_back(cyc); end
        if (ws8) begin sq8.push_back(s8); sc8.push_back(cyc); end
    end

    int n_vec = 0;
    int n_bad = 0;
    int bd4, bd8, bs4, bs8;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic mark();
        bd4 = dq4.size(); bd8 = dq8.size();
        bs4 = sq4.size(); bs8 = sq8.size();
    endtask

    task automatic set_dst(input logic [95:0] d);
        dport = d[95:80]; dmac = d[79:32]; dip = d[31:0];
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit fl);
        logic r;
        bit   ok;
        ok = 1'b0;
        in_data = d;
        if (sel) begin v8 = 1'b1; f8 = fl; end
        else     begin v4 = 1'b1; f4 = fl; end
        for (int i = 0; i < 200; i++) begin
            r = sel ? rdy8 : rdy4;
            @(negedge clk);
            if (r) begin ok = 1'b1; break; end
        end
        v4 = 1'b0; v8 = 1'b0; f4 = 1'b0; f8 = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic pulse_flush(input bit sel);
        if (sel) f8 = 1'b1; else f4 = 1'b1;
        @(negedge clk);
        f4 = 1'b0; f8 = 1'b0;
    endtask

    task automatic wait_status(input bit sel, input int n);
        int got;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            got = sel ? sq8.size() - bs8 : sq4.size() - bs4;
            if (got >= n) break;
            @(negedge clk);
        end
        chk("status_wait", got, n);
    endtask

    task automatic get_data(input bit sel, output logic [63:0] g,
                            output int n);
        int b;
        g = '0;
        b = sel ? bd8 : bd4;
        n = (sel ? dq8.size() : dq4.size()) - b;
        for (int i = 0; i < n && i < 8; i++)
            g[8*i +: 8] = sel ? dq8[b+i] : dq4[b+i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mark();
    endtask

    typedef struct {
        bit          sel;
        int          n;
        logic [63:0] din;
        int          fl;
        logic [95:0] dst;
        logic [63:0] exp;
        int          pkt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [63:0] g;
        int          n;
        logic [95:0] ea, eb;

        // fl: 0 none, 1 flush on the cycle after the last byte, 2 flush with it
        tbl[0] = '{1'b0, 4, 64'h04030201, 0,
                   {16'h1F90, 48'h0011_2233_4455, 32'hC0A8_0101},
                   64'h04030201, 1};
        tbl[1] = '{1'b0, 4, 64'h08070605, 2,
                   {16'h1F91, 48'h0011_2233_4466, 32'hC0A8_0102},
                   64'h08070605, 2};
        tbl[2] = '{1'b0, 2, 64'h2211, 1,
                   {16'h0035, 48'hFFFF_FFFF_FFFF, 32'h0A00_0001},
                   64'h00002211, 3};
        tbl[3] = '{1'b1, 3, 64'hCCBBAA, 1,
                   {16'hABCD, 48'h0200_0000_0003, 32'h0A00_0003},
                   64'h0000_0000_00CC_BBAA, 1};
        tbl[4] = '{1'b1, 8, 64'h8877_6655_4433_2211, 0,
                   {16'h0400, 48'h0200_0000_0004, 32'h0A00_0004},
                   64'h8877_6655_4433_2211, 2};
        tbl[5] = '{1'b1, 1, 64'h5A, 2,
                   {16'h0500, 48'h0200_0000_0005, 32'h0A00_0005},
                   64'h0000_0000_0000_005A, 3};
        tbl[6] = '{1'b1, 7, 64'h0007_0605_0403_0201, 1,
                   {16'h0600, 48'h0200_0000_0006, 32'h0A00_0006},
                   64'h0007_0605_0403_0201, 4};

        rst = 1'b1; in_data = 8'h00;
        v4 = 1'b0; v8 = 1'b0; f4 = 1'b0; f8 = 1'b0;
        used = 13'd0; sfull = 1'b0;
        set_dst(96'd0);
        repeat (3) @(negedge clk);
        chk("rst_ctl4", {rdy4, wd4, ws4, busy4, d4}, 0);
        chk("rst_stat4", s4, 0);
        chk("rst_pc4", pc4, 0);
        chk("rst_ctl8", {rdy8, wd8, ws8, busy8, d8}, 0);
        chk("rst_stat8", s8, 0);
        chk("rst_pc8", pc8, 0);
        rst = 1'b0;
        mark();

        for (int k = 0; k < 7; k++) begin
            mark();
            set_dst(tbl[k].dst);
            for (int i = 0; i < tbl[k].n; i++)
                send(tbl[k].sel, tbl[k].din[8*i +: 8],
                     tbl[k].fl == 2 && i == tbl[k].n - 1);
            if (tbl[k].fl == 1) pulse_flush(tbl[k].sel);
            wait_status(tbl[k].sel, 1);
            get_data(tbl[k].sel, g, n);
            chk($sformatf("v%0d_count", k), n, tbl[k].sel ? 8 : 4);
            chk($sformatf("v%0d_data", k), g, tbl[k].exp);
            if (tbl[k].sel) begin
                chk($sformatf("v%0d_status", k), sq8[bs8], tbl[k].dst);
                chk($sformatf("v%0d_pkt", k), pc8, tbl[k].pkt);
                chk($sformatf("v%0d_gap", k), sc8[bs8] - dc8[dc8.size()-1], 1);
            end else begin
                chk($sformatf("v%0d_status", k), sq4[bs4], tbl[k].dst);
                chk($sformatf("v%0d_pkt", k), pc4, tbl[k].pkt);
                chk($sformatf("v%0d_gap", k), sc4[bs4] - dc4[dc4.size()-1], 1);
            end
        end

        // Back-to-back packets at minimum period
        do_reset();
        ea = {16'h0101, 48'hAAAA_0000_0001, 32'h0101_0101};
        eb = {16'h0202, 48'hBBBB_0000_0002, 32'h0202_0202};
        set_dst(ea);
        for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 1'b0);
        set_dst(eb);
        for (int i = 5; i <= 8; i++) send(1'b0, 8'(i), 1'b0);
        wait_status(1'b0, 2);
        get_data(1'b0, g, n);
        chk("cont_data", g, 64'h0807_0605_0403_0201);
        chk("cont_st0", sq4[bs4], ea);
        chk("cont_st1", sq4[bs4+1], eb);
        chk("cont_period", sc4[bs4+1] - sc4[bs4], 7);
        chk("cont_pkt", pc4, 2);

        // Flush in IDLE makes no packet
        do_reset();
        pulse_flush(1'b1);
        repeat (20) @(negedge clk);
        chk("idle_flush_data", dq8.size() - bd8, 0);
        chk("idle_flush_stat", sq8.size() - bs8, 0);
        chk("idle_flush_pkt", pc8, 0);

        // Data FIFO room check at its boundary
        do_reset();
        ea = {16'h0303, 48'hCCCC_0000_0003, 32'h0303_0303};
        set_dst(ea);
        used = 13'd8190;
        in_data = 8'h31; v4 = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_8190_ready", rdy4, 0);
        chk("bp_8190_busy", busy4, 1);
        used = 13'd8187;
        repeat (3) @(negedge clk);
        chk("bp_8187_ready", rdy4, 0);
        used = 13'd8186;
        @(negedge clk);
        chk("bp_8186_ready", rdy4, 1);
        v4 = 1'b0;
        chk("bp_nodata", dq4.size() - bd4, 0);
        for (int i = 0; i < 4; i++) send(1'b0, 8'h31 + 8'(i), 1'b0);
        wait_status(1'b0, 1);
        get_data(1'b0, g, n);
        chk("bp_data", g, 64'h34333231);
        chk("bp_status", sq4[bs4], ea);
        used = 13'd0;

        // Status FIFO full holds off the packet
        do_reset();
        sfull = 1'b1;
        in_data = 8'h41; v4 = 1'b1;
        repeat (8) @(negedge clk);
        chk("sfull_nodata", dq4.size() - bd4, 0);
        chk("sfull_ready", rdy4, 0);
        sfull = 1'b0; v4 = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 8'h41 + 8'(i), 1'b0);
        wait_status(1'b0, 1);
        get_data(1'b0, g, n);
        chk("sfull_data", g, 64'h44434241);
        chk("sfull_pkt", pc4, 1);

        // Reset in the middle of FILL
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b0, 8'h51 + 8'(i), 1'b0);
        wait_status(1'b0, 1);
        chk("mid_pre_pkt", pc4, 1);
        send(1'b0, 8'h61, 1'b0);
        send(1'b0, 8'h62, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {rdy4, wd4, ws4, busy4, d4}, 0);
        chk("mid_rst_stat", s4, 0);
        chk("mid_rst_pkt", pc4, 0);
        rst = 1'b0;
        mark();
        ea = {16'h0707, 48'h0707_0000_0007, 32'h0707_0707};
        set_dst(ea);
        for (int i = 0; i < 4; i++) send(1'b0, 8'h71 + 8'(i), 1'b0);
        wait_status(1'b0, 1);
        get_data(1'b0, g, n);
        chk("mid_new_count", n, 4);
        chk("mid_new_data", g, 64'h74737271);
        chk("mid_new_status", sq4[bs4], ea);
        chk("mid_new_pkt", pc4, 1);

        // Partial packet left idle
        do_reset();
        send(1'b1, 8'hA1, 1'b0);
        send(1'b1, 8'hA2, 1'b0);
        repeat (40) @(negedge clk);
`ifdef PKT_TIMEOUT_EN
        wait_status(1'b1, 1);
        get_data(1'b1, g, n);
        chk("to_count", n, 8);
        chk("to_data", g, 64'h0000_0000_0000_A2A1);
        chk("to_delay", dc8[bd8+2] - dc8[bd8+1], 11);
`else
        chk("to_count", dq8.size() - bd8, 2);
        chk("to_nostat", sq8.size() - bs8, 0);
        chk("to_busy", busy8, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
